// File: rtl/ysyx_23060096_mem_arbiter.sv
// Single-port memory arbiter between IFU (read-only) and LSU (read/write).
// Optional WAIT timeout with error response: define YSYX_23060096_ARB_TIMEOUT_EN.
module ysyx_23060096_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MW = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_last_owner;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [MW-1:0]     r_wmask;

    logic w_idle;
    logic w_ifu_win;
    logic w_lsu_win;
    logic w_rsp;
    logic w_tmo;
    logic w_done;

    // Owner encoding: 0 = IFU, 1 = LSU; a tie goes to whoever was not served last
    assign w_idle    = (r_state == S_IDLE);
    assign w_ifu_win = w_idle & ifu_req_valid & (~lsu_req_valid | r_last_owner);
    assign w_lsu_win = w_idle & lsu_req_valid & (~ifu_req_valid | ~r_last_owner);
    assign w_rsp     = (r_state == S_WAIT) & mem_rsp_valid;
    assign w_done    = w_rsp | w_tmo;

`ifdef YSYX_23060096_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] r_cnt;

    assign w_tmo = (r_state == S_WAIT) & ~mem_rsp_valid
                 & (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if ((r_state == S_REQ) && mem_req_ready) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT) && !w_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_unused_tmo;

    assign w_tmo        = 1'b0;
    assign w_unused_tmo = (TIMEOUT == 0);
`endif

    assign ifu_req_ready = w_ifu_win;
    assign lsu_req_ready = w_lsu_win;

    assign ifu_rsp_valid = w_done & ~r_owner;
    assign lsu_rsp_valid = w_done & r_owner;
    assign ifu_rsp_err   = w_tmo & ~r_owner;
    assign lsu_rsp_err   = w_tmo & r_owner;
    assign ifu_rdata     = (w_rsp & ~r_owner) ? mem_rdata : '0;
    assign lsu_rdata     = (w_rsp & r_owner) ? mem_rdata : '0;

    assign mem_req_valid = r_req_valid;
    assign mem_addr      = r_addr;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b0;
            r_req_valid  <= 1'b0;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_lsu_win) begin
                        r_addr       <= lsu_addr;
                        r_wen        <= lsu_wen;
                        r_wdata      <= lsu_wdata;
                        r_wmask      <= lsu_wmask;
                        r_owner      <= 1'b1;
                        r_last_owner <= 1'b1;
                        r_req_valid  <= 1'b1;
                        r_state      <= S_REQ;
                    end else if (w_ifu_win) begin
                        r_addr       <= ifu_addr;
                        r_wen        <= 1'b0;
                        r_wdata      <= '0;
                        r_wmask      <= '0;
                        r_owner      <= 1'b0;
                        r_last_owner <= 1'b0;
                        r_req_valid  <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_req_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_mem_arbiter.sv
// Scoreboard bench for ysyx_23060096_mem_arbiter: directed IFU/LSU traffic,
// monitor checks memory requests and responses against queued expectations.
module tb_ysyx_23060096_mem_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    typedef struct packed {
        logic        lsu;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rdata;
    logic        ifu_rsp_err;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rdata;
    logic        lsu_rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ifu_q[$];
    req_t        lsu_q[$];
    req_t        exp_req[$];
    rsp_t        exp_rsp[$];

    ysyx_23060096_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_addr     (ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rdata    (ifu_rdata),
        .ifu_rsp_err  (ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_ready(lsu_req_ready),
        .lsu_addr     (lsu_addr),
        .lsu_wen      (lsu_wen),
        .lsu_wdata    (lsu_wdata),
        .lsu_wmask    (lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rdata    (lsu_rdata),
        .lsu_rsp_err  (lsu_rsp_err),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr     (mem_addr),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset_outs(input string nm);
        chk(nm, {mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
                 ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid, lsu_rsp_err,
                 ifu_rdata, lsu_rdata}, '0);
    endtask

    // IFU requester: holds valid with the queue head until accepted
    initial begin
        logic acc;
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        forever begin
            @(negedge clk);
            acc = ifu_req_valid && ifu_req_ready && rstn;
            @(posedge clk);
            #1;
            if (acc && ifu_q.size() > 0) void'(ifu_q.pop_front());
            if (rstn && ifu_q.size() > 0) begin
                ifu_req_valid = 1'b1;
                ifu_addr      = ifu_q[0];
            end else begin
                ifu_req_valid = 1'b0;
            end
        end
    end

    initial begin
        logic acc;
        lsu_req_valid = 1'b0;
        lsu_addr      = '0;
        lsu_wen       = 1'b0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        forever begin
            @(negedge clk);
            acc = lsu_req_valid && lsu_req_ready && rstn;
            @(posedge clk);
            #1;
            if (acc && lsu_q.size() > 0) void'(lsu_q.pop_front());
            if (rstn && lsu_q.size() > 0) begin
                lsu_req_valid = 1'b1;
                lsu_addr      = lsu_q[0].addr;
                lsu_wen       = lsu_q[0].wen;
                lsu_wdata     = lsu_q[0].wdata;
                lsu_wmask     = lsu_q[0].wmask;
            end else begin
                lsu_req_valid = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or response
    initial begin
        req_t r;
        rsp_t s;
        forever begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) begin
                if (exp_req.size() == 0) begin
                    chk("unexpected_mem_req", {mem_addr, mem_wen}, '0);
                end else begin
                    r = exp_req.pop_front();
                    chk("mem_req_fields",
                        {mem_addr, mem_wen, mem_wdata, mem_wmask}, r);
                end
            end
            if (ifu_rsp_valid || lsu_rsp_valid) begin
                chk("rsp_onehot", {ifu_rsp_valid, lsu_rsp_valid},
                    {~lsu_rsp_valid, lsu_rsp_valid});
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", {ifu_rsp_valid, lsu_rsp_valid}, '0);
                end else begin
                    s = exp_rsp.pop_front();
                    if (s.lsu) chk("lsu_rsp", {lsu_rsp_valid, lsu_rdata, lsu_rsp_err},
                                   {1'b1, s.data, s.err});
                    else       chk("ifu_rsp", {ifu_rsp_valid, ifu_rdata, ifu_rsp_err},
                                   {1'b1, s.data, s.err});
                end
            end
            if (!ifu_rsp_valid) chk("ifu_rdata_quiet", {ifu_rdata, ifu_rsp_err}, '0);
            if (!lsu_rsp_valid) chk("lsu_rdata_quiet", {lsu_rdata, lsu_rsp_err}, '0);
        end
    end

    // Memory side: wait for a request, stall, accept, optionally respond at once
    task automatic serve(input int rdy_wait, input bit respond,
                         input logic [31:0] data);
        int t;
        logic [68:0] snap;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!mem_req_valid && t < 50);
        if (!mem_req_valid) begin
            chk("serve_req_timeout", 0, 1);
            return;
        end
        snap = {mem_addr, mem_wen, mem_wdata, mem_wmask};
        for (int i = 0; i < rdy_wait; i++) begin
            @(negedge clk);
            chk("req_hold", {mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask},
                {1'b1, snap});
        end
        @(posedge clk);
        #1 mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        if (respond) begin
            mem_rsp_valid = 1'b1;
            mem_rdata     = data;
            @(posedge clk);
            #1;
            mem_rsp_valid = 1'b0;
            mem_rdata     = '0;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        check_reset_outs("reset_outs");
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        int t;
        int rdy_cnt;
        rstn          = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        repeat (2) @(negedge clk);
        check_reset_outs("por_outs");
        chk("por_readys", {ifu_req_ready, lsu_req_ready}, '0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // IFU-only fetch with handshake latency check
        @(negedge clk);
        ifu_q.push_back(32'h8000_0000);
        exp_req.push_back('{32'h8000_0000, 1'b0, 32'h0, 4'h0});
        exp_rsp.push_back('{1'b0, 32'h0000_0413, 1'b0});
        fork
            serve(0, 1'b1, 32'h0000_0413);
            begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!ifu_req_ready && t < 20);
                chk("ifu_ready_seen", ifu_req_ready, 1);
                chk("lsu_ready_off", lsu_req_ready, 0);
                @(negedge clk);
                chk("ifu_ready_one_cycle", ifu_req_ready, 0);
                chk("mem_valid_next", mem_req_valid, 1);
            end
        join

        // LSU write held through three stalled cycles
        @(negedge clk);
        lsu_q.push_back('{32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF});
        exp_req.push_back('{32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF});
        exp_rsp.push_back('{1'b1, 32'h0, 1'b0});
        serve(3, 1'b1, 32'h0);

        // Fresh reset, then both requesters valid: LSU, IFU, LSU, IFU
        pulse_reset();
        @(negedge clk);
        lsu_q.push_back('{32'h8000_3000, 1'b0, 32'h0, 4'h0});
        lsu_q.push_back('{32'h8000_3004, 1'b1, 32'hA5A5_A5A5, 4'h3});
        ifu_q.push_back(32'h8000_0010);
        ifu_q.push_back(32'h8000_0014);
        exp_req.push_back('{32'h8000_3000, 1'b0, 32'h0, 4'h0});
        exp_req.push_back('{32'h8000_0010, 1'b0, 32'h0, 4'h0});
        exp_req.push_back('{32'h8000_3004, 1'b1, 32'hA5A5_A5A5, 4'h3});
        exp_req.push_back('{32'h8000_0014, 1'b0, 32'h0, 4'h0});
        exp_rsp.push_back('{1'b1, 32'h1111_1111, 1'b0});
        exp_rsp.push_back('{1'b0, 32'h2222_2222, 1'b0});
        exp_rsp.push_back('{1'b1, 32'h3333_3333, 1'b0});
        exp_rsp.push_back('{1'b0, 32'h4444_4444, 1'b0});
        serve(0, 1'b1, 32'h1111_1111);
        serve(1, 1'b1, 32'h2222_2222);
        serve(0, 1'b1, 32'h3333_3333);
        serve(0, 1'b1, 32'h4444_4444);

        // Spurious response while idle, then a normal fetch
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("spurious_ignored", {ifu_rsp_valid, lsu_rsp_valid}, '0);
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        @(negedge clk);
        ifu_q.push_back(32'h8000_0020);
        exp_req.push_back('{32'h8000_0020, 1'b0, 32'h0, 4'h0});
        exp_rsp.push_back('{1'b0, 32'h0050_0093, 1'b0});
        serve(0, 1'b1, 32'h0050_0093);

        // Reset during WAIT, late response after release must be dropped
        @(negedge clk);
        ifu_q.push_back(32'h8000_0030);
        exp_req.push_back('{32'h8000_0030, 1'b0, 32'h0, 4'h0});
        serve(0, 1'b0, 32'h0);
        pulse_reset();
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1234_5678;
        @(negedge clk);
        check_reset_outs("late_rsp_after_reset");
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;

        // LSU read that memory never answers
        @(negedge clk);
        lsu_q.push_back('{32'h8000_2000, 1'b0, 32'h0, 4'h0});
        exp_req.push_back('{32'h8000_2000, 1'b0, 32'h0, 4'h0});
`ifdef YSYX_23060096_ARB_TIMEOUT_EN
        exp_rsp.push_back('{1'b1, 32'h0, 1'b1});
        serve(0, 1'b0, 32'h0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!lsu_rsp_valid && t < 20);
        chk("timeout_wait_cycles", t, 8);
        @(negedge clk);
        ifu_q.push_back(32'h8000_0040);
        exp_req.push_back('{32'h8000_0040, 1'b0, 32'h0, 4'h0});
        exp_rsp.push_back('{1'b0, 32'h0000_0013, 1'b0});
        serve(0, 1'b1, 32'h0000_0013);
`else
        serve(0, 1'b0, 32'h0);
        @(negedge clk);
        ifu_q.push_back(32'h8000_0040);
        rdy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifu_req_ready || lsu_req_valid) rdy_cnt++;
        end
        chk("wait_holds_no_grant", rdy_cnt, 0);
        chk("wait_no_req", mem_req_valid, 0);
        @(posedge clk);
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        ifu_q.delete();
        check_reset_outs("abandon_wait_reset");
        @(posedge clk);
        #1 rstn = 1'b1;
`endif

        repeat (5) @(negedge clk);
        chk("exp_req_drained", exp_req.size(), 0);
        chk("exp_rsp_drained", exp_rsp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
